// File: rtl/poly94_video_pkg.sv
// -----------------------------------------------------------------------------
// poly94_video_pkg
// Shared types and constants for the video fetch path.
//   - fetch_state_e : burst fetcher FSM encoding
//   - SDRAM_ADDR_W / SDRAM_DATA_W : video SDRAM port widths
//   - DEF_* : default fetcher configuration
//   - sat_sub() : saturating subtract used for the words-remaining count
// -----------------------------------------------------------------------------
package poly94_video_pkg;

  localparam int SDRAM_ADDR_W    = 24;
  localparam int SDRAM_DATA_W    = 16;

  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_FIFO_DEPTH  = 32;
  localparam int DEF_FRAME_WORDS = 76800;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_DATA     = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_ACK      = 3'd4
  } fetch_state_e;

  // a - b, clamped at zero
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    if (a > b) begin
      res = a - b;
    end else begin
      res = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/video_line_fifo.sv
// -----------------------------------------------------------------------------
// video_line_fifo
// Synchronous first-word-fall-through FIFO. The head word is visible on
// rdata_o whenever empty_o is low; rdata_o reads as zero while empty.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop all contents (wins over push/pop)
//   push_i, wdata_i write one word (ignored when full)
//   pop_i           remove head word (ignored when empty)
//   rdata_o         head word
//   count_o         occupancy, 0..DEPTH
//   empty_o, full_o status flags
// -----------------------------------------------------------------------------
module video_line_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (count_r == {(AW+1){1'b0}});
  assign full_o    = (count_r == DEPTH_C);
  assign count_o   = count_r;
  assign push_ok_s = push_i & ~full_o & ~flush_i;
  assign pop_ok_s  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o   = empty_o ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array; write port only, no reset needed on data
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  // Pointers and occupancy; flush returns to empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/video_burst_fetcher.sv
// -----------------------------------------------------------------------------
// video_burst_fetcher
// Video initiator on the SDRAM arbiter. Streams FRAME_WORDS 16-bit words from
// a linear framebuffer into a FWFT FIFO using one outstanding burst read at a
// time, and hands them to the pixel pipeline over valid/ready.
// A burst is requested only when the FIFO can absorb all of it, so response
// beats are never back-pressured.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   frame_start_i             pulse: restart fetch at base_addr_x16_i
//   base_addr_x16_i           framebuffer base (16-bit word address)
//   video_sdram_cmd_valid/ready, video_sdram_addr_x16   burst request
//   video_sdram_rdy           controller idle after the transaction
//   video_sdram_ack           one-cycle release pulse to the arbiter
//   video_sdram_resp_valid/last, video_sdram_rdata       read beats
//   pix_valid_o/ready_i/data_o  pixel stream (FIFO head)
//   underflow_o               sticky consumer-starved flag for this frame
//
// Optional build macro VIDEO_FETCH_STATS_EN adds:
//   underflow_count_o         saturating count of starved cycles this frame
//   max_fill_o                FIFO occupancy high-water mark
// -----------------------------------------------------------------------------
module video_burst_fetcher
  import poly94_video_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      frame_start_i,
  input  logic [SDRAM_ADDR_W-1:0]   base_addr_x16_i,
  output logic                      video_sdram_cmd_valid,
  input  logic                      video_sdram_cmd_ready,
  output logic [SDRAM_ADDR_W-1:0]   video_sdram_addr_x16,
  input  logic                      video_sdram_rdy,
  output logic                      video_sdram_ack,
  input  logic                      video_sdram_resp_valid,
  input  logic                      video_sdram_resp_last,
  input  logic [SDRAM_DATA_W-1:0]   video_sdram_rdata,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic [SDRAM_DATA_W-1:0]   pix_data_o,
  output logic                      underflow_o
`ifdef VIDEO_FETCH_STATS_EN
  ,
  output logic [15:0]               underflow_count_o,
  output logic [$clog2(FIFO_DEPTH):0] max_fill_o
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  localparam logic [CNT_W-1:0]        DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]        BURST_C   = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]       BURST_B   = BEAT_W'(BURST_LEN);
  localparam logic [31:0]             BURST_W32 = 32'(BURST_LEN);
  localparam logic [31:0]             FRAME_C   = 32'(FRAME_WORDS);
  localparam logic [SDRAM_ADDR_W-1:0] ADDR_STEP = SDRAM_ADDR_W'(BURST_LEN);

  fetch_state_e              state_r;
  fetch_state_e              state_s;
  logic                      cmd_valid_r;
  logic                      ack_r;
  logic [SDRAM_ADDR_W-1:0]   addr_r;
  logic [31:0]               remaining_r;
  logic                      frame_active_r;
  logic                      discard_r;
  logic                      underflow_r;
  logic [BEAT_W-1:0]         beat_cnt_r;
  logic [BEAT_W-1:0]         keep_r;

  logic [CNT_W-1:0]          fifo_count_s;
  logic                      fifo_empty_s;
  logic                      fifo_full_s;
  logic [SDRAM_DATA_W-1:0]   fifo_rdata_s;
  logic [CNT_W-1:0]          free_s;
  logic                      can_req_s;
  logic                      accept_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      starve_s;

  // A pending request is withdrawn combinationally in the frame_start_i
  // cycle so the arbiter can never accept a stale address.
  assign video_sdram_cmd_valid = cmd_valid_r & ~frame_start_i;
  assign video_sdram_addr_x16  = addr_r;
  assign video_sdram_ack       = ack_r;
  assign accept_s              = video_sdram_cmd_valid & video_sdram_cmd_ready;

  // Only one burst is ever in flight and requests start from IDLE, so no
  // beats are reserved at the point this is evaluated.
  assign free_s    = DEPTH_C - fifo_count_s;
  assign can_req_s = frame_active_r & (remaining_r != 32'd0) & (free_s >= BURST_C);

  // Beats past the frame end, beats of an aborted burst and a beat that
  // coincides with a restart never enter the FIFO.
  assign push_s = (state_r == ST_DATA) & video_sdram_resp_valid & ~discard_r &
                  ~frame_start_i & (beat_cnt_r < keep_r) & ~fifo_full_s;
  assign pop_s    = ~fifo_empty_s & pix_ready_i;
  assign starve_s = frame_active_r & pix_ready_i & fifo_empty_s;

  assign pix_valid_o = ~fifo_empty_s;
  assign pix_data_o  = fifo_rdata_s;
  assign underflow_o = underflow_r;

  video_line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SDRAM_DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (frame_start_i),
    .push_i  (push_s),
    .wdata_i (video_sdram_rdata),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

  // Next-state logic for the burst FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!frame_start_i && can_req_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (frame_start_i) begin
          state_s = ST_IDLE;
        end else if (accept_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DATA: begin
        if (video_sdram_resp_valid && video_sdram_resp_last) begin
          state_s = ST_WAIT_RDY;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_WAIT_RDY: begin
        if (video_sdram_rdy) begin
          state_s = ST_ACK;
        end else begin
          state_s = ST_WAIT_RDY;
        end
      end
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with command/ack outputs registered from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      cmd_valid_r <= 1'b0;
      ack_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_valid_r <= (state_s == ST_REQ);
      ack_r       <= (state_s == ST_ACK);
    end
  end

  // Fetch address, remaining words, final-burst keep length, discard flag.
  // The address may reload while a burst is in flight: the in-flight burst
  // already latched its own address at acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r      <= {SDRAM_ADDR_W{1'b0}};
      remaining_r <= 32'd0;
      keep_r      <= {BEAT_W{1'b0}};
      discard_r   <= 1'b0;
    end else if (frame_start_i) begin
      addr_r      <= base_addr_x16_i;
      remaining_r <= FRAME_C;
      keep_r      <= keep_r;
      discard_r   <= discard_r | (state_r == ST_DATA);
    end else if (accept_s) begin
      addr_r      <= addr_r + ADDR_STEP;
      remaining_r <= sat_sub(remaining_r, BURST_W32);
      keep_r      <= (remaining_r >= BURST_W32) ? BURST_B : BEAT_W'(remaining_r);
      discard_r   <= 1'b0;
    end
  end

  // Beat index within the current burst, saturating at BURST_LEN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (accept_s) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if ((state_r == ST_DATA) && video_sdram_resp_valid && (beat_cnt_r != BURST_B)) begin
      beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
    end
  end

  // Frame is active from frame_start until every word is fetched and drained
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_active_r <= 1'b0;
    end else if (frame_start_i) begin
      frame_active_r <= 1'b1;
    end else if ((remaining_r == 32'd0) && (state_r == ST_IDLE) && fifo_empty_s) begin
      frame_active_r <= 1'b0;
    end
  end

  // Sticky underflow flag, cleared per frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underflow_r <= 1'b0;
    end else if (frame_start_i) begin
      underflow_r <= 1'b0;
    end else if (starve_s) begin
      underflow_r <= 1'b1;
    end
  end

`ifdef VIDEO_FETCH_STATS_EN
  logic [15:0]      ucount_r;
  logic [CNT_W-1:0] max_fill_r;

  assign underflow_count_o = ucount_r;
  assign max_fill_o        = max_fill_r;

  // Saturating count of starved consumer cycles, cleared per frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ucount_r <= 16'd0;
    end else if (frame_start_i) begin
      ucount_r <= 16'd0;
    end else if (starve_s && (ucount_r != 16'hFFFF)) begin
      ucount_r <= ucount_r + 16'd1;
    end
  end

  // FIFO occupancy high-water mark
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_fill_r <= {CNT_W{1'b0}};
    end else if (fifo_count_s > max_fill_r) begin
      max_fill_r <= fifo_count_s;
    end
  end
`endif

endmodule

// File: doc/video_burst_fetcher.md
Name: video_burst_fetcher

Overview:
- Initiator on the arbiter's video SDRAM port.
- Streams a linear framebuffer region from SDRAM into an internal FIFO using burst reads, and presents the words to the pixel pipeline over a valid/ready stream.
- One burst is outstanding at a time. A new burst is issued only when the FIFO has room for a full burst, so response beats never need back-pressure.

Parameters:
- BURST_LEN, 8: 16-bit beats per SDRAM burst; must match the controller burst length; power of two.
- FIFO_DEPTH, 32: FIFO entries (16-bit); power of two, at least 2*BURST_LEN.
- FRAME_WORDS, 76800: words fetched per frame (320x240 at 16 bpp).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- frame_start_i  in  1  one-cycle pulse; restart fetch at base_addr_x16_i
- base_addr_x16_i  in  24  framebuffer base, 16-bit word address; sampled on frame_start_i
- video_sdram_cmd_valid  out  1  burst request
- video_sdram_cmd_ready  in  1  arbiter accepts the request this cycle
- video_sdram_addr_x16  out  24  burst start address
- video_sdram_rdy  in  1  controller idle after the transaction
- video_sdram_ack  out  1  one-cycle release pulse to the arbiter
- video_sdram_resp_valid  in  1  read beat valid
- video_sdram_resp_last  in  1  final beat of the burst
- video_sdram_rdata  in  16  read beat data
- pix_valid_o  out  1  FIFO not empty
- pix_ready_i  in  1  consumer pops
- pix_data_o  out  16  FIFO head word
- underflow_o  out  1  sticky: pix_ready_i seen while the FIFO was empty during an active frame; cleared by frame_start_i

Behaviour:
- Reset, asynchronous on rst_ni low:
  - state IDLE, FIFO empty, fetch address 0, words remaining 0.
  - All outputs 0: cmd_valid, ack, pix_valid_o, underflow_o; addr and pix_data_o are 0.
- States:
  - IDLE: wait for a frame to be active.
  - REQ: cmd_valid=1, addr = current fetch address.
    - The address is held stable until cmd_valid && cmd_ready.
    - The request is only entered when words_remaining >= 1 and free slots (FIFO_DEPTH minus occupancy, minus beats already reserved) >= BURST_LEN.
  - DATA: each resp_valid beat is pushed into the FIFO in the same cycle. resp_last moves to WAIT_RDY.
  - WAIT_RDY: wait for video_sdram_rdy=1.
  - ACK: ack=1 for exactly one cycle, then IDLE.
    - Must not be re-entered within the same transaction.
    - The earliest next REQ is the cycle after ACK, so the arbiter sees busy cleared first.
- Address and length:
  - The fetch address advances by BURST_LEN on command acceptance and wraps modulo 2^24.
  - words_remaining decrements by BURST_LEN, saturating at 0.
  - When FRAME_WORDS is not a multiple of BURST_LEN, the beats of the final burst beyond FRAME_WORDS are discarded, not pushed.
- FIFO:
  - First-word-fall-through: pix_data_o is valid whenever pix_valid_o=1.
  - Pop occurs on pix_valid_o && pix_ready_i.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - Overflow cannot occur by construction. The bench asserts it never does.
- frame_start_i with no burst in flight (IDLE/REQ before acceptance):
  - FIFO flushed, the address reloads from base_addr_x16_i, words_remaining = FRAME_WORDS, underflow cleared.
  - A REQ not yet accepted is withdrawn in the same cycle.
- frame_start_i during DATA/WAIT_RDY/ACK:
  - The SDRAM burst cannot be aborted. The FIFO is flushed, and a discard flag drops all remaining beats of the current burst.
  - The new frame's first REQ follows the ACK.
- frame_start_i coincident with resp_last: that beat is discarded, and the restart proceeds as above.
- resp_valid outside DATA is ignored. The bench flags it as a protocol error.

Optional Feature:
- Macro VIDEO_FETCH_STATS_EN.
- Defined:
  - Adds output underflow_count_o[15:0], counting cycles with pix_ready_i=1 and the FIFO empty during an active frame.
  - Saturates at 16'hFFFF, is cleared on frame_start_i, and resets to 0.
  - Adds output max_fill_o[$clog2(FIFO_DEPTH):0], the high-water mark of the FIFO occupancy.
- Undefined: neither port exists and no counter logic is generated. Behaviour is otherwise identical.

Decomposition:
- Package poly94_video_pkg:
  - fetch state enum (IDLE, REQ, DATA, WAIT_RDY, ACK).
  - SDRAM_ADDR_W=24, SDRAM_DATA_W=16.
  - Default BURST_LEN and FRAME_WORDS constants.
- Sub-module video_line_fifo: synchronous FWFT FIFO (DEPTH, WIDTH) with push, pop, flush, count, empty and full.

Test Plan:
- Basic burst: BURST_LEN=8, base 24'h000100, frame_start, cmd_ready=1 -> cmd_valid with addr 000100; 8 beats (last on the 8th); rdy after 2 cycles -> exactly one ack pulse; next REQ addr 000108.
- Back-pressure: pix_ready_i=0, FIFO_DEPTH=32 -> exactly 4 bursts issued, count=32, no 5th REQ; pop 8 words -> 5th REQ issued with addr base+32.
- Arbiter stall: cmd_ready=0 for 10 cycles -> cmd_valid and addr stable throughout; accepted on the first cycle ready=1.
- Mid-burst restart: frame_start_i after beat 3 with new base 24'h200000 -> beats 4-8 dropped, pix_valid_o=0, ack still issued, then REQ addr 200000.
- Frame end: FRAME_WORDS=20, BURST_LEN=8 -> bursts at base, base+8 and base+16; last 4 beats of the third burst dropped; 20 words delivered; no further REQ.
- Underflow: pix_ready_i=1 with the FIFO empty after frame_start -> underflow_o=1 sticky; with VIDEO_FETCH_STATS_EN, underflow_count_o equals the stall cycles; both cleared by the next frame_start_i.
